direct_map_ctrl: RTL and testbench
==================================

# direct_map_ctrl

Miss-handling controller that drives the `direct_map` tag/data array from a CPU-side request port and a word-wide memory port. It performs lookups and store-merges on hits. On a miss it writes back a dirty victim, refills the line from memory and replays the access. It sits between the core's load/store unit and the memory bus, one instance per `direct_map` array.

## Interface
Parameters:
- `CACHE_SIZE`, 1024: cache capacity in bytes; must match the array instance.
- `LINE_SIZE`, 4: line size in bytes; only 4 (one 32-bit word) is supported, elaboration error otherwise.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cpu_req_valid`  in  1  CPU request valid.
- `cpu_req_ready`  out  1  controller accepts a request.
- `cpu_req_addr`  in  32  byte address.
- `cpu_req_write`  in  1  1 = store, 0 = load.
- `cpu_req_wdata`  in  32  store data.
- `cpu_req_wstrb`  in  4  store byte enables.
- `cpu_resp_valid`  out  1  one-cycle completion pulse; no back-pressure.
- `cpu_resp_rdata`  out  32  load data, valid with `cpu_resp_valid`.
- `arr_addr`  out  32  array lookup/write address.
- `arr_hit`  in  1  array hit, valid one cycle after `arr_addr`.
- `arr_dirty`  in  1  victim dirty flag, same timing.
- `arr_data`  in  32  line data, same timing.
- `arr_invalidate_addr`  in  32  victim address, same timing.
- `arr_write_data`  out  32  array write data.
- `arr_write_strb`  out  4  array byte strobes.
- `arr_write_valid`  out  1  array write enable.
- `arr_write_access`  out  1  1 = CPU store (merge and set dirty), 0 = refill (clean).
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  32  word-aligned address, bits [1:0] = 0.
- `mem_req_write`  out  1  1 = writeback, 0 = refill read.
- `mem_req_wdata`  out  32  writeback data.
- `mem_resp_valid`  in  1  exactly one pulse per accepted request; acknowledges writes too.
- `mem_resp_rdata`  in  32  refill data.

## Operation
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RELOAD. Reset state is IDLE.
- IDLE:
  - `cpu_req_ready`=1 and `arr_addr`=`cpu_req_addr`.
  - On handshake, latch addr/write/wdata/wstrb and go to LOOKUP.
- LOOKUP, hit:
  - Pulse `cpu_resp_valid` with `cpu_resp_rdata`=`arr_data`.
  - For a store, also assert `arr_write_valid`=1, `arr_write_access`=1, `arr_write_data`=latched wdata, `arr_write_strb`=latched wstrb.
  - Go to IDLE.
- LOOKUP, miss:
  - Latch `arr_invalidate_addr` with [1:0] cleared, and `arr_data`, as the victim.
  - Dirty victim: go to WB_REQ. Clean victim: go to RF_REQ.
- WB_REQ:
  - Drive `mem_req_valid`=1, `mem_req_write`=1, victim address and data.
  - Hold all fields stable until `mem_req_ready`, then go to WB_WAIT.
- WB_WAIT: on `mem_resp_valid`, go to RF_REQ.
- RF_REQ:
  - Drive `mem_req_valid`=1, `mem_req_write`=0, `mem_req_addr`={latched addr[31:2],2'b00}.
  - On ready, go to RF_WAIT.
- RF_WAIT: on `mem_resp_valid`, assert `arr_write_valid`=1, `arr_write_access`=0, `arr_write_data`=`mem_resp_rdata`, `arr_write_strb`=4'hF, then go to RELOAD.
- RELOAD: no write; re-presents the address, then goes to LOOKUP. The replay is guaranteed to hit, and a store merges there.
- Outside IDLE, `arr_addr` = latched request address.
- `mem_resp_valid` outside WB_WAIT/RF_WAIT is ignored.
- Tag array contents are zero at configuration (all lines invalid). Flush and invalidate are out of scope.
- `cpu_req_addr[1:0]` is passed to the array unchanged and does not affect lookup.

## Timing
- Reset values: state IDLE, `cpu_req_ready`=1 (requester must not issue while `rst_n` is low), all other outputs 0.
- Hit latency: request accepted in cycle 0, `cpu_resp_valid` in cycle 1. Throughput is one request per 2 cycles.
- Miss latency (clean victim): 1 + RF_REQ wait + RF_WAIT wait + 2 cycles.
- Dirty victim adds the WB_REQ and WB_WAIT durations.
- Zero memory stall gives 5 cycles for a clean miss and 7 cycles for a dirty miss.
- `mem_resp_valid` is accepted no earlier than the cycle after the request handshake.
- Reset asserted mid-transaction returns to IDLE immediately. The outstanding memory transaction is abandoned; the memory side is reset together with this block.
- All `mem_req_*` outputs are registered. `cpu_req_ready` and `arr_addr` are combinational from state.

## Structure
- Package `direct_map_ctrl_pkg`: state enum `ctrl_state_e` and localparam `WORD_BYTES`=4.
- Single FSM module, no sub-module. The integration wrapper that pairs it with `direct_map` is a separate block.

## Test plan
- Cold load to 0x0000_0100, memory returns 0xDEAD_BEEF:
  - One read request to 0x100 appears.
  - Array written clean.
  - Replay hits; `cpu_resp_rdata`=0xDEAD_BEEF 5 cycles after accept with a zero-stall memory.
- Load 0x100 again: `cpu_resp_valid` in cycle 1; no memory request.
- Store 0x0000_00AA, wstrb=4'b0001 to 0x100, then load 0x100: returns 0xDEAD_BEAA.
- Load 0x0000_0500 (same set as 0x100, dirty):
  - Writeback of 0xDEAD_BEAA to 0x100 precedes a read of 0x500.
  - `mem_req_valid` is held across 3 cycles of `mem_req_ready`=0 with stable fields.
- Store miss to a clean set:
  - Refill is followed by RELOAD, then a merged write with `arr_write_access`=1.
  - A subsequent eviction writes back the merged word.
- `rst_n` pulsed low during RF_WAIT:
  - All outputs return to their reset values.
  - A stray `mem_resp_valid` after reset is ignored.
  - The next load completes normally.

Source files
------------

// File: rtl/direct_map_ctrl_pkg.sv
// Shared definitions for the direct_map miss-handling controller.
// Holds the FSM state encoding and the word geometry it assumes.
package direct_map_ctrl_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WB_REQ  = 3'd2,
    WB_WAIT = 3'd3,
    RF_REQ  = 3'd4,
    RF_WAIT = 3'd5,
    RELOAD  = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/direct_map_ctrl.sv
// Miss-handling controller for a one-word-per-line direct_map array.
// Serves CPU hits/store-merges, writes back dirty victims and refills on misses.
module direct_map_ctrl
  import direct_map_ctrl_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_req_addr,
  input  logic        cpu_req_write,
  input  logic [31:0] cpu_req_wdata,
  input  logic [3:0]  cpu_req_wstrb,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  output logic [31:0] arr_addr,
  input  logic        arr_hit,
  input  logic        arr_dirty,
  input  logic [31:0] arr_data,
  input  logic [31:0] arr_invalidate_addr,
  output logic [31:0] arr_write_data,
  output logic [3:0]  arr_write_strb,
  output logic        arr_write_valid,
  output logic        arr_write_access,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_write,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  if (LINE_SIZE != WORD_BYTES) begin : g_line_size_check
    $error("direct_map_ctrl: only LINE_SIZE == 4 is supported");
  end
  if ((CACHE_SIZE < LINE_SIZE) || ((CACHE_SIZE & (CACHE_SIZE - 1)) != 0)) begin : g_cache_size_check
    $error("direct_map_ctrl: CACHE_SIZE must be a power of two no smaller than LINE_SIZE");
  end

  localparam logic [31:0] WORD_MASK = ~32'(WORD_BYTES - 1);

  ctrl_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic        mem_req_write_q, mem_req_write_d;
  logic [31:0] mem_req_addr_q, mem_req_addr_d;
  logic [31:0] mem_req_wdata_q, mem_req_wdata_d;

  logic [31:0] refill_addr;
  logic        lookup_hit;

  assign refill_addr = addr_q & WORD_MASK;
  assign lookup_hit  = (state_q == LOOKUP) && arr_hit;

  // The victim latched on a miss lives directly in the registered memory request fields.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    write_d         = write_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_write_d = mem_req_write_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          state_d = LOOKUP;
          addr_d  = cpu_req_addr;
          write_d = cpu_req_write;
          wdata_d = cpu_req_wdata;
          wstrb_d = cpu_req_wstrb;
        end
      end
      LOOKUP: begin
        if (arr_hit) begin
          state_d = IDLE;
        end else if (arr_dirty) begin
          state_d         = WB_REQ;
          mem_req_valid_d = 1'b1;
          mem_req_write_d = 1'b1;
          mem_req_addr_d  = arr_invalidate_addr & WORD_MASK;
          mem_req_wdata_d = arr_data;
        end else begin
          state_d         = RF_REQ;
          mem_req_valid_d = 1'b1;
          mem_req_write_d = 1'b0;
          mem_req_addr_d  = refill_addr;
          mem_req_wdata_d = '0;
        end
      end
      WB_REQ: begin
        if (mem_req_ready) begin
          state_d         = WB_WAIT;
          mem_req_valid_d = 1'b0;
        end
      end
      WB_WAIT: begin
        if (mem_resp_valid) begin
          state_d         = RF_REQ;
          mem_req_valid_d = 1'b1;
          mem_req_write_d = 1'b0;
          mem_req_addr_d  = refill_addr;
          mem_req_wdata_d = '0;
        end
      end
      RF_REQ: begin
        if (mem_req_ready) begin
          state_d         = RF_WAIT;
          mem_req_valid_d = 1'b0;
        end
      end
      RF_WAIT: begin
        if (mem_resp_valid) begin
          state_d = RELOAD;
        end
      end
      RELOAD: begin
        state_d = LOOKUP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    arr_write_valid  = 1'b0;
    arr_write_access = 1'b0;
    arr_write_data   = '0;
    arr_write_strb   = '0;
    if (lookup_hit && write_q) begin
      arr_write_valid  = 1'b1;
      arr_write_access = 1'b1;
      arr_write_data   = wdata_q;
      arr_write_strb   = wstrb_q;
    end else if ((state_q == RF_WAIT) && mem_resp_valid) begin
      arr_write_valid  = 1'b1;
      arr_write_access = 1'b0;
      arr_write_data   = mem_resp_rdata;
      arr_write_strb   = 4'hF;
    end
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign arr_addr       = (state_q == IDLE) ? cpu_req_addr : addr_q;
  assign cpu_resp_valid = lookup_hit;
  assign cpu_resp_rdata = lookup_hit ? arr_data : '0;

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_write  = mem_req_write_q;
  assign mem_req_addr   = mem_req_addr_q;
  assign mem_req_wdata  = mem_req_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      write_q         <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      write_q         <= write_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_write_q <= mem_req_write_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
    end
  end

endmodule

// File: tb/tb_direct_map_ctrl.sv
// Bench for direct_map_ctrl: array and memory models plus a scoreboard
// fed by a golden word-memory / cache-occupancy reference model.
module tb_direct_map_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_req_write = 1'b0;
  logic [31:0] cpu_req_wdata = '0;
  logic [3:0]  cpu_req_wstrb = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic [31:0] arr_addr;
  logic        arr_hit = 1'b0;
  logic        arr_dirty = 1'b0;
  logic [31:0] arr_data = '0;
  logic [31:0] arr_invalidate_addr = '0;
  logic [31:0] arr_write_data;
  logic [3:0]  arr_write_strb;
  logic        arr_write_valid;
  logic        arr_write_access;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_req_write;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;

  always #5 clk = ~clk;

  direct_map_ctrl #(.CACHE_SIZE(1024), .LINE_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_write(cpu_req_write),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .arr_addr(arr_addr), .arr_hit(arr_hit), .arr_dirty(arr_dirty),
    .arr_data(arr_data), .arr_invalidate_addr(arr_invalidate_addr),
    .arr_write_data(arr_write_data), .arr_write_strb(arr_write_strb),
    .arr_write_valid(arr_write_valid), .arr_write_access(arr_write_access),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          accept_cycle;
  } resp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } memreq_t;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  resp_t   resp_q[$];
  memreq_t mem_q[$];

  logic [31:0] golden  [logic [31:0]];
  logic [31:0] backing [logic [31:0]];
  logic        ref_valid [0:255];
  logic        ref_dirty [0:255];
  logic [21:0] ref_tag   [0:255];

  logic        a_valid [0:255];
  logic        a_dirty [0:255];
  logic [21:0] a_tag   [0:255];
  logic [31:0] a_data  [0:255];

  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;
  int rf_wr_cnt = 0, st_wr_cnt = 0, rd_hs_cnt = 0, stall_seen = 0;
  int refill_wr_cycle = 0, store_wr_cycle = 0;
  int force_stall = 0, extra_delay = 0;
  bit random_mode = 0, stray_pulse = 0, pending = 0;
  int resp_cycle = 0;
  logic [31:0] resp_data = '0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic logic [31:0] golden_rd(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] backing_rd(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Issue one request, then predict its response and memory traffic from the golden model.
  task automatic applyStimulus(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int lat_adj);
    logic        accepted;
    logic [31:0] wa;
    logic [7:0]  s;
    logic [21:0] t;
    logic        hit, dvict;
    resp_t       e;
    memreq_t     m;
    accepted = 1'b0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_write = write;
    cpu_req_wdata = wdata;
    cpu_req_wstrb = wstrb;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cpu_req_ready) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!accepted) begin
      checkOutput("req_accept_timeout", 32'd0, 32'd1);
      return;
    end
    wa    = {addr[31:2], 2'b00};
    s     = addr[9:2];
    t     = addr[31:10];
    hit   = ref_valid[s] && (ref_tag[s] == t);
    dvict = !hit && ref_valid[s] && ref_dirty[s];
    e.rdata        = golden_rd(wa);
    e.accept_cycle = cycle;
    e.lat          = (lat_adj < 0) ? -1 : ((hit ? 1 : (dvict ? 7 : 5)) + lat_adj);
    if (!hit) begin
      if (dvict) begin
        m.write = 1'b1;
        m.addr  = {ref_tag[s], s, 2'b00};
        m.data  = golden_rd(m.addr);
        mem_q.push_back(m);
      end
      m.write = 1'b0;
      m.addr  = wa;
      m.data  = '0;
      mem_q.push_back(m);
      ref_valid[s] = 1'b1;
      ref_tag[s]   = t;
      ref_dirty[s] = 1'b0;
    end
    if (write) begin
      golden[wa]   = merge_word(golden_rd(wa), wdata, wstrb);
      ref_dirty[s] = 1'b1;
      cur_wdata    = wdata;
      cur_wstrb    = wstrb;
    end
    resp_q.push_back(e);
  endtask

  task automatic waitDone(input int budget);
    bit done;
    done = 0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (resp_q.size() == 0 && mem_q.size() == 0 && cpu_req_ready) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", 32'(resp_q.size() + mem_q.size()), 32'd0);
  endtask

  task automatic checkReset();
    checkOutput("rst_req_ready", 32'(cpu_req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", cpu_resp_rdata, 32'd0);
    checkOutput("rst_arr_addr", arr_addr, 32'd0);
    checkOutput("rst_arr_wvalid", 32'(arr_write_valid), 32'd0);
    checkOutput("rst_arr_waccess", 32'(arr_write_access), 32'd0);
    checkOutput("rst_arr_wdata", arr_write_data, 32'd0);
    checkOutput("rst_arr_wstrb", 32'(arr_write_strb), 32'd0);
    checkOutput("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_req_write), 32'd0);
    checkOutput("rst_mem_addr", mem_req_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_req_wdata, 32'd0);
  endtask

  // Array model: write-first, lookup result presented the cycle after arr_addr.
  initial begin : array_model
    logic [31:0] look;
    logic [7:0]  idx;
    for (int i = 0; i < 256; i++) begin
      a_valid[i] = 0; a_dirty[i] = 0; a_tag[i] = '0; a_data[i] = '0;
    end
    forever begin
      @(negedge clk);
      look = arr_addr;
      idx  = look[9:2];
      if (rst_n && arr_write_valid) begin
        if (arr_write_access) begin
          checkOutput("arr_st_data", arr_write_data, cur_wdata);
          checkOutput("arr_st_strb", 32'(arr_write_strb), 32'(cur_wstrb));
          a_data[idx]  = merge_word(a_data[idx], arr_write_data, arr_write_strb);
          a_dirty[idx] = 1'b1;
          store_wr_cycle = cycle;
          st_wr_cnt++;
        end else begin
          checkOutput("arr_rf_strb", 32'(arr_write_strb), 32'hF);
          checkOutput("arr_rf_data", arr_write_data, mem_resp_rdata);
          checkOutput("arr_rf_respv", 32'(mem_resp_valid), 32'd1);
          a_valid[idx] = 1'b1;
          a_tag[idx]   = look[31:10];
          a_data[idx]  = arr_write_data;
          a_dirty[idx] = 1'b0;
          refill_wr_cycle = cycle;
          rf_wr_cnt++;
        end
      end
      @(posedge clk); #1;
      arr_hit   = a_valid[idx] && (a_tag[idx] == look[31:10]);
      arr_dirty = a_valid[idx] && a_dirty[idx];
      arr_data  = a_data[idx];
      arr_invalidate_addr = {a_tag[idx], idx, 2'b11};
    end
  end

  // Memory model and memory-side monitor: every request cycle is compared with the predicted request.
  initial begin : mem_model
    memreq_t f;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        checkOutput("mem_addr_align", 32'(mem_req_addr[1:0]), 32'd0);
        if (mem_q.size() == 0) begin
          checkOutput("mem_unexp_valid", 32'(mem_req_valid), 32'd0);
        end else begin
          f = mem_q[0];
          checkOutput("mem_write", 32'(mem_req_write), 32'(f.write));
          checkOutput("mem_addr", mem_req_addr, f.addr);
          if (f.write) checkOutput("mem_wdata", mem_req_wdata, f.data);
        end
        if (mem_req_ready) begin
          if (mem_q.size() > 0) void'(mem_q.pop_front());
          pending    = 1;
          resp_cycle = cycle + 1 + (random_mode ? int'($urandom_range(0, 3)) : extra_delay);
          if (mem_req_write) begin
            backing[mem_req_addr] = mem_req_wdata;
            resp_data = $urandom;
          end else begin
            resp_data = backing_rd(mem_req_addr);
            rd_hs_cnt++;
          end
        end else begin
          stall_seen++;
        end
      end
      @(posedge clk); #1;
      if (!rst_n) pending = 0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      if (stray_pulse) begin
        mem_resp_valid = 1'b1;
        stray_pulse    = 0;
      end else if (pending && cycle >= resp_cycle) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = resp_data;
        pending        = 0;
      end
      if (force_stall > 0 && mem_req_valid) begin
        mem_req_ready = 1'b0;
        force_stall--;
      end else if (random_mode) begin
        mem_req_ready = ($urandom_range(0, 2) != 0);
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  initial begin : cpu_monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_resp_valid) begin
        if (resp_q.size() == 0) begin
          checkOutput("resp_unexpected", 32'(cpu_resp_valid), 32'd0);
        end else begin
          e = resp_q.pop_front();
          checkOutput("resp_rdata", cpu_resp_rdata, e.rdata);
          if (e.lat >= 0) checkOutput("resp_latency", 32'(cycle - e.accept_cycle), 32'(e.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no_finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int          rd0, rf0, st0;
    logic [31:0] merged;
    logic [7:0]  ss;
    logic        sv_valid, sv_dirty;
    logic [21:0] sv_tag;
    bit          seen;

    for (int i = 0; i < 256; i++) begin
      ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = '0;
    end
    golden[32'h100]  = 32'hDEADBEEF;
    backing[32'h100] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    rd0 = rd_hs_cnt; rf0 = rf_wr_cnt;
    applyStimulus(32'h100, 1'b0, '0, 4'h0, 0);
    waitDone(100);
    checkOutput("cold_rd_count", 32'(rd_hs_cnt - rd0), 32'd1);
    checkOutput("cold_refill_writes", 32'(rf_wr_cnt - rf0), 32'd1);

    rd0 = rd_hs_cnt;
    applyStimulus(32'h100, 1'b0, '0, 4'h0, 0);
    waitDone(100);
    checkOutput("hit_rd_count", 32'(rd_hs_cnt - rd0), 32'd0);

    st0 = st_wr_cnt;
    applyStimulus(32'h100, 1'b1, 32'h0000_00AA, 4'b0001, 0);
    applyStimulus(32'h100, 1'b0, '0, 4'h0, 0);
    waitDone(100);
    checkOutput("hit_store_writes", 32'(st_wr_cnt - st0), 32'd1);

    force_stall = 3;
    rd0 = stall_seen;
    applyStimulus(32'h500, 1'b0, '0, 4'h0, 3);
    waitDone(100);
    checkOutput("wb_stall_cycles", 32'(stall_seen - rd0), 32'd3);
    checkOutput("wb_data_0x100", backing_rd(32'h100), 32'hDEADBEAA);

    applyStimulus(32'h204, 1'b1, 32'h1234_5678, 4'b0110, 0);
    waitDone(100);
    checkOutput("store_after_reload", 32'(store_wr_cycle - refill_wr_cycle), 32'd2);
    applyStimulus(32'h604, 1'b0, '0, 4'h0, 0);
    waitDone(100);
    merged = init_word(32'h204);
    merged[23:8] = 16'h3456;
    checkOutput("merged_wb_0x204", backing_rd(32'h204), merged);

    // Reset while the refill is outstanding; the model forgets the abandoned miss.
    ss = 8'hC2;
    sv_valid = ref_valid[ss]; sv_dirty = ref_dirty[ss]; sv_tag = ref_tag[ss];
    extra_delay = 6;
    rd0 = rd_hs_cnt;
    applyStimulus(32'h308, 1'b0, '0, 4'h0, -1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_hs_cnt > rd0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("rfwait_reach_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = '0;
    pending = 0;
    resp_q.delete();
    mem_q.delete();
    ref_valid[ss] = sv_valid; ref_dirty[ss] = sv_dirty; ref_tag[ss] = sv_tag;
    extra_delay = 0;
    @(negedge clk);
    checkReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray_pulse = 1;
    rf0 = rf_wr_cnt;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stray_arr_wvalid", 32'(arr_write_valid), 32'd0);
      checkOutput("stray_resp_valid", 32'(cpu_resp_valid), 32'd0);
      checkOutput("stray_req_ready", 32'(cpu_req_ready), 32'd1);
    end
    checkOutput("stray_refill_writes", 32'(rf_wr_cnt - rf0), 32'd0);
    applyStimulus(32'h308, 1'b0, '0, 4'h0, 0);
    waitDone(100);

    random_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra;
      ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), -1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
      end
    end
    waitDone(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
